// File: rtl/spi_host_pkg.sv
// Shared types and constants for the SPI host master.
package spi_host_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        WAIT,
        HOLD,
        GAP
    } state_e;

    localparam logic [1:0] SEL_IO   = 2'd0;
    localparam logic [1:0] SEL_DATA = 2'd1;
    localparam logic [1:0] SEL_OSD  = 2'd2;
    localparam logic [1:0] SEL_NONE = 2'd3;

    // Per-transfer attributes latched when a byte is accepted.
    typedef struct packed {
        logic [1:0] sel;
        logic       last;
    } xfer_t;

    // Active-low select vector {ss3, ss2, ss_io} for a target select code.
    function automatic logic [2:0] sel_decode(input logic [1:0] sel);
        logic [2:0] ss_n;
        ss_n = 3'b111;
        case (sel)
            SEL_IO:   ss_n = 3'b110;
            SEL_DATA: ss_n = 3'b101;
            SEL_OSD:  ss_n = 3'b011;
            default:  ss_n = 3'b111;
        endcase
        return ss_n;
    endfunction

endpackage

// File: rtl/spi_host_master_half_tick.sv
// SCK half-period timer: one-cycle tick at the end of each CLK_DIV-cycle half-period.
module spi_half_tick #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick_c
);

    localparam int unsigned  CW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick_c = en && (cnt_q == '0);

    // Reload on clear or at each tick, otherwise count down while enabled.
    always_comb begin
        cnt_d = cnt_q;
        if (clr || tick_c) begin
            cnt_d = RELOAD;
        end else if (en) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= RELOAD;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_host_master.sv
// Byte-oriented SPI mode-0 master driving the guest core's SPI slave pins.
module spi_host_master
    import spi_host_pkg::*;
#(
    parameter int unsigned CLK_DIV  = 2,
    parameter int unsigned CS_SETUP = 2,
    parameter int unsigned CS_HOLD  = 2
) (
    input  logic       CLOCK_27,
    input  logic       RESET_N,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_data,
    input  logic [1:0] cmd_sel,
    input  logic       cmd_last,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       busy,
    output logic       spi_sck,
    output logic       spi_mosi,
    input  logic       spi_miso,
    output logic       spi_ss_io,
    output logic       spi_ss2,
    output logic       spi_ss3
);

    localparam int unsigned   CNT_MAX      = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
    localparam int unsigned   CNT_W        = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] SETUP_RELOAD = CNT_W'(CS_SETUP - 1);
    localparam logic [CNT_W-1:0] HOLD_RELOAD  = CNT_W'(CS_HOLD - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic             sck_q, sck_d;
    logic             mosi_q, mosi_d;
    logic [6:0]       tx_q, tx_d;
    logic [7:0]       rx_q, rx_d;
    xfer_t            xfer_q, xfer_d;
    logic             rsp_pend_q, rsp_pend_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic [7:0]       rsp_data_q, rsp_data_d;
    logic [2:0]       ss_q, ss_d;
    logic             busy_q, busy_d;
    logic             cmd_ready_q, cmd_ready_d;

    logic accept_c;
    logic miso_c;
    logic tick_c;
    logic tick_clr_c;

    assign accept_c = cmd_valid && cmd_ready_q;
    // The guest updates MISO off our own SCK fall, so it is stable at the sample edge.
    assign miso_c   = (xfer_q.sel == SEL_NONE) ? 1'b1 : spi_miso;

    spi_half_tick #(
        .CLK_DIV(CLK_DIV)
    ) u_half_tick (
        .clk   (CLOCK_27),
        .rst_n (RESET_N),
        .clr   (tick_clr_c),
        .en    (state_q == SHIFT),
        .tick_c(tick_c)
    );

    // Next-state, shift-register and output decode.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        sck_d       = sck_q;
        mosi_d      = mosi_q;
        tx_d        = tx_q;
        rx_d        = rx_q;
        xfer_d      = xfer_q;
        rsp_pend_d  = 1'b0;
        rsp_valid_d = rsp_pend_q;
        rsp_data_d  = rsp_pend_q ? rx_q : rsp_data_q;
        tick_clr_c  = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    tx_d        = cmd_data[6:0];
                    mosi_d      = cmd_data[7];
                    xfer_d.sel  = cmd_sel;
                    xfer_d.last = cmd_last;
                    bit_d       = 3'd0;
                    cnt_d       = SETUP_RELOAD;
                    state_d     = SETUP;
                end
            end
            SETUP: begin
                if (cnt_q == '0) begin
                    tick_clr_c = 1'b1;
                    state_d    = SHIFT;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            SHIFT: begin
                if (tick_c) begin
                    sck_d = !sck_q;
                    // End of a high phase: sample, drop SCK, present next bit.
                    if (sck_q) begin
                        rx_d   = {rx_q[6:0], miso_c};
                        tx_d   = {tx_q[5:0], 1'b0};
                        mosi_d = tx_q[6];
                        bit_d  = bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
                            rsp_pend_d = 1'b1;
                            if (xfer_q.last) begin
                                cnt_d   = HOLD_RELOAD;
                                state_d = HOLD;
                            end else begin
                                state_d = WAIT;
                            end
                        end
                    end
                end
            end
            WAIT: begin
                // Continuation byte: select already low, skip setup, keep latched sel.
                if (accept_c) begin
                    tx_d        = cmd_data[6:0];
                    mosi_d      = cmd_data[7];
                    xfer_d.last = cmd_last;
                    bit_d       = 3'd0;
                    tick_clr_c  = 1'b1;
                    state_d     = SHIFT;
                end
            end
            HOLD: begin
                if (cnt_q == '0) begin
                    cnt_d   = HOLD_RELOAD;
                    state_d = GAP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            GAP: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        ss_d = 3'b111;
        if (state_d inside {SETUP, SHIFT, WAIT, HOLD}) begin
            ss_d = sel_decode(xfer_d.sel);
        end
        busy_d      = (state_d != IDLE);
        cmd_ready_d = (state_d == IDLE) || (state_d == WAIT);
    end

    // State and output registers.
    always_ff @(posedge CLOCK_27 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_q       <= 3'd0;
            sck_q       <= 1'b0;
            mosi_q      <= 1'b0;
            tx_q        <= 7'd0;
            rx_q        <= 8'd0;
            xfer_q      <= '0;
            rsp_pend_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 8'd0;
            ss_q        <= 3'b111;
            busy_q      <= 1'b0;
            cmd_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            sck_q       <= sck_d;
            mosi_q      <= mosi_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            xfer_q      <= xfer_d;
            rsp_pend_q  <= rsp_pend_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            ss_q        <= ss_d;
            busy_q      <= busy_d;
            cmd_ready_q <= cmd_ready_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = busy_q;
    assign spi_sck   = sck_q;
    assign spi_mosi  = mosi_q;
    assign spi_ss_io = ss_q[0];
    assign spi_ss2   = ss_q[1];
    assign spi_ss3   = ss_q[2];

endmodule

// File: tb/tb_spi_host_master.sv
// Directed bench for spi_host_master with a behavioural mode-0 SPI slave.
module tb_spi_host_master;

    logic       CLOCK_27 = 1'b0;
    logic       RESET_N  = 1'b0;

    logic       cmd_valid = 1'b0;
    logic [7:0] cmd_data  = 8'd0;
    logic [1:0] cmd_sel   = 2'd0;
    logic       cmd_last  = 1'b0;
    logic       cmd_ready, rsp_valid, busy, spi_sck, spi_mosi;
    logic       spi_ss_io, spi_ss2, spi_ss3;
    logic [7:0] rsp_data;
    logic       slv_miso = 1'b0;

    logic       cmd_valid4 = 1'b0;
    logic [7:0] cmd_data4  = 8'd0;
    logic       cmd_last4  = 1'b0;
    logic       miso4      = 1'b1;
    logic       cmd_ready4, rsp_valid4, busy4, sck4, mosi4, ss_io4, ss2_4, ss3_4;
    logic [7:0] rsp_data4;

    int total = 0;
    int bad   = 0;

    always #5 CLOCK_27 = ~CLOCK_27;

    spi_host_master #(.CLK_DIV(2), .CS_SETUP(2), .CS_HOLD(2)) u_dut (
        .CLOCK_27(CLOCK_27), .RESET_N(RESET_N),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
        .cmd_sel(cmd_sel), .cmd_last(cmd_last),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
        .spi_sck(spi_sck), .spi_mosi(spi_mosi), .spi_miso(slv_miso),
        .spi_ss_io(spi_ss_io), .spi_ss2(spi_ss2), .spi_ss3(spi_ss3)
    );

    spi_host_master #(.CLK_DIV(4), .CS_SETUP(2), .CS_HOLD(2)) u_dut4 (
        .CLOCK_27(CLOCK_27), .RESET_N(RESET_N),
        .cmd_valid(cmd_valid4), .cmd_ready(cmd_ready4), .cmd_data(cmd_data4),
        .cmd_sel(2'd1), .cmd_last(cmd_last4),
        .rsp_valid(rsp_valid4), .rsp_data(rsp_data4), .busy(busy4),
        .spi_sck(sck4), .spi_mosi(mosi4), .spi_miso(miso4),
        .spi_ss_io(ss_io4), .spi_ss2(ss2_4), .spi_ss3(ss3_4)
    );

    // ---------------- slave model and bus monitor ----------------
    logic [7:0] slv_reply [0:63];
    logic [5:0] slv_idx   = 6'd0;
    logic [7:0] slv_sh    = 8'd0;
    int         slv_bits  = 0;

    wire  [2:0] ss_now = {spi_ss3, spi_ss2, spi_ss_io};
    wire        sel_any = (ss_now != 3'b111);
    logic       sck_p = 1'b0;
    logic [2:0] ss_p  = 3'b111;
    int cyc = 0, rise_cnt = 0, rsp_cnt = 0;
    int io_low = 0, ss2_low = 0, ss3_low = 0, ss2_rise = 0;
    int last_fall_cyc = 0, last_ssrise_cyc = 0;
    int multi_low = 0, chg_hi = 0;
    logic       mosi_hist [$];
    logic [7:0] rsp_hist  [$];

    always @(negedge CLOCK_27) begin
        cyc   <= cyc + 1;
        sck_p <= spi_sck;
        ss_p  <= ss_now;
        if (spi_sck && !sck_p) begin
            rise_cnt <= rise_cnt + 1;
            mosi_hist.push_back(spi_mosi);
        end
        if (!spi_sck && sck_p) last_fall_cyc <= cyc;
        if ((ss_now & ~ss_p) != 3'b000) last_ssrise_cyc <= cyc;
        if (!spi_ss_io) io_low <= io_low + 1;
        if (!spi_ss2)   ss2_low <= ss2_low + 1;
        if (!spi_ss3)   ss3_low <= ss3_low + 1;
        if (spi_ss2 && !ss_p[1]) ss2_rise <= ss2_rise + 1;
        if ($countones(~ss_now) > 1) multi_low <= multi_low + 1;
        if (RESET_N && (ss_now != ss_p) && (spi_sck || sck_p)) chg_hi <= chg_hi + 1;
        if (rsp_valid) begin
            rsp_cnt <= rsp_cnt + 1;
            rsp_hist.push_back(rsp_data);
        end
        // Mode-0 slave: first bit on select fall, later bits on SCK fall.
        if (sel_any && (ss_p == 3'b111)) begin
            slv_sh   <= slv_reply[slv_idx];
            slv_miso <= slv_reply[slv_idx][7];
            slv_idx  <= slv_idx + 6'd1;
            slv_bits <= 0;
        end else if (sel_any && !spi_sck && sck_p) begin
            if (slv_bits == 7) begin
                slv_sh   <= slv_reply[slv_idx];
                slv_miso <= slv_reply[slv_idx][7];
                slv_idx  <= slv_idx + 6'd1;
                slv_bits <= 0;
            end else begin
                slv_sh   <= {slv_sh[6:0], 1'b0};
                slv_miso <= slv_sh[6];
                slv_bits <= slv_bits + 1;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLOCK_27);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] d, input logic [1:0] s, input logic l);
        int n = 0;
        while (!cmd_ready && n < 500) begin
            tick(1);
            n++;
        end
        total++;
        if (cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL send_ready: cmd_ready=%b after %0d cycles, required 1", cmd_ready, n);
        end
        cmd_valid = 1'b1;
        cmd_data  = d;
        cmd_sel   = s;
        cmd_last  = l;
        tick(1);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 1000) begin
            tick(1);
            n++;
        end
        tick(2);
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL %s_idle: busy=%b after %0d cycles, required 0", name, busy, n);
        end
    endtask

    function automatic logic [7:0] mosi_byte(input int base);
        logic [7:0] b;
        b = 8'd0;
        for (int i = 0; i < 8; i++) b = {b[6:0], mosi_hist[base + i]};
        return b;
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        tick(3);
        total++;
        if ({spi_ss3, spi_ss2, spi_ss_io, spi_sck, spi_mosi, rsp_valid, busy} !== 7'b1110000) begin
            bad++;
            $display("FAIL reset_pins: ss3/ss2/io/sck/mosi/rv/busy=%b, required 1110000",
                     {spi_ss3, spi_ss2, spi_ss_io, spi_sck, spi_mosi, rsp_valid, busy});
        end
        total++;
        if (rsp_data !== 8'h00) begin
            bad++;
            $display("FAIL reset_rsp_data: got %h, required 00", rsp_data);
        end
        RESET_N = 1'b1;
        tick(2);
        total++;
        if (cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_ready: cmd_ready=%b, required 1", cmd_ready);
        end
    endtask

    task automatic test_single();
        int r0 = rise_cnt;
        int m0 = mosi_hist.size();
        int p0 = rsp_cnt;
        int o0 = ss2_low + ss3_low;
        slv_reply[slv_idx] = 8'h3C;
        send(8'hA5, 2'd0, 1'b1);
        total++;
        if ({spi_ss_io, spi_mosi} !== 2'b01) begin
            bad++;
            $display("FAIL single_setup: ss_io/mosi=%b, required 01", {spi_ss_io, spi_mosi});
        end
        wait_idle("single");
        total++;
        if (rise_cnt - r0 != 8) begin
            bad++;
            $display("FAIL single_rises: got %0d, required 8", rise_cnt - r0);
        end
        total++;
        if (mosi_byte(m0) !== 8'hA5) begin
            bad++;
            $display("FAIL single_mosi: got %h, required a5", mosi_byte(m0));
        end
        total++;
        if (rsp_cnt - p0 != 1 || rsp_hist[p0] !== 8'h3C) begin
            bad++;
            $display("FAIL single_rsp: pulses=%0d data=%h, required 1 and 3c", rsp_cnt - p0, rsp_hist[p0]);
        end
        total++;
        if (last_ssrise_cyc - last_fall_cyc != 2) begin
            bad++;
            $display("FAIL single_hold: select rose %0d cycles after last fall, required 2",
                     last_ssrise_cyc - last_fall_cyc);
        end
        total++;
        if (ss2_low + ss3_low != o0 || rsp_data !== 8'h3C) begin
            bad++;
            $display("FAIL single_other: other-select low cycles=%0d rsp_data=%h, required 0 and 3c",
                     ss2_low + ss3_low - o0, rsp_data);
        end
    endtask

    task automatic test_burst();
        int r0 = rise_cnt;
        int m0 = mosi_hist.size();
        int p0 = rsp_cnt;
        int s0 = ss2_rise;
        int o0 = io_low + ss3_low;
        slv_reply[slv_idx]         = 8'h01;
        slv_reply[slv_idx + 6'd1]  = 8'h02;
        slv_reply[slv_idx + 6'd2]  = 8'h03;
        send(8'h14, 2'd1, 1'b0);
        send(8'h00, 2'd1, 1'b0);
        send(8'hFF, 2'd1, 1'b1);
        wait_idle("burst");
        total++;
        if (rise_cnt - r0 != 24 || ss2_rise - s0 != 1) begin
            bad++;
            $display("FAIL burst_frame: rises=%0d ss2 rises=%0d, required 24 and 1",
                     rise_cnt - r0, ss2_rise - s0);
        end
        total++;
        if ({mosi_byte(m0), mosi_byte(m0 + 8), mosi_byte(m0 + 16)} !== 24'h1400FF) begin
            bad++;
            $display("FAIL burst_mosi: got %h %h %h, required 14 00 ff",
                     mosi_byte(m0), mosi_byte(m0 + 8), mosi_byte(m0 + 16));
        end
        total++;
        if (rsp_cnt - p0 != 3 || {rsp_hist[p0], rsp_hist[p0 + 1], rsp_hist[p0 + 2]} !== 24'h010203) begin
            bad++;
            $display("FAIL burst_rsp: pulses=%0d, required 3 carrying 01 02 03", rsp_cnt - p0);
        end
        total++;
        if (io_low + ss3_low != o0) begin
            bad++;
            $display("FAIL burst_other: other-select low cycles=%0d, required 0", io_low + ss3_low - o0);
        end
    endtask

    task automatic test_latency_div4();
        int n;
        cmd_valid4 = 1'b1;
        cmd_data4  = 8'h3A;
        cmd_last4  = 1'b0;
        tick(1);
        cmd_valid4 = 1'b0;
        n = 0;
        while (!rsp_valid4 && n < 200) begin
            tick(1);
            n++;
        end
        total++;
        if (n != 67) begin
            bad++;
            $display("FAIL lat_idle: rsp_valid %0d cycles after accept, required 67", n);
        end
        total++;
        if (cmd_ready4 !== 1'b1 || ss2_4 !== 1'b0) begin
            bad++;
            $display("FAIL lat_wait_state: ready=%b ss2=%b, required 1 and 0", cmd_ready4, ss2_4);
        end
        cmd_valid4 = 1'b1;
        cmd_data4  = 8'hC5;
        cmd_last4  = 1'b1;
        tick(1);
        cmd_valid4 = 1'b0;
        n = 0;
        while (!rsp_valid4 && n < 200) begin
            tick(1);
            n++;
        end
        total++;
        if (n != 65) begin
            bad++;
            $display("FAIL lat_wait: rsp_valid %0d cycles after accept, required 65", n);
        end
        tick(1);
        total++;
        if (rsp_valid4 !== 1'b0 || rsp_data4 !== 8'hFF) begin
            bad++;
            $display("FAIL lat_pulse: rsp_valid=%b rsp_data=%h, required 0 and ff", rsp_valid4, rsp_data4);
        end
        tick(20);
    endtask

    task automatic test_wait_hold();
        int errs = 0;
        int n;
        int m0;
        slv_reply[slv_idx]        = 8'h42;
        slv_reply[slv_idx + 6'd1] = 8'hE7;
        send(8'h81, 2'd0, 1'b0);
        n = 0;
        while (!rsp_valid && n < 200) begin
            tick(1);
            n++;
        end
        tick(1);
        for (int i = 0; i < 1000; i++) begin
            if (spi_ss_io !== 1'b0 || spi_sck !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b1) errs++;
            tick(1);
        end
        total++;
        if (errs != 0) begin
            bad++;
            $display("FAIL wait_hold: %0d cycles with wrong ss/sck/ready/busy, required 0", errs);
        end
        m0 = mosi_hist.size();
        send(8'h7E, 2'd3, 1'b1);
        n = 0;
        while (!rsp_valid && n < 200) begin
            tick(1);
            n++;
        end
        total++;
        if (n != 33 || rsp_data !== 8'hE7) begin
            bad++;
            $display("FAIL wait_resume: latency=%0d data=%h, required 33 and e7", n, rsp_data);
        end
        wait_idle("wait");
        total++;
        if (mosi_byte(m0) !== 8'h7E) begin
            bad++;
            $display("FAIL wait_mosi: got %h, required 7e", mosi_byte(m0));
        end
    endtask

    task automatic test_reset_mid();
        int r0 = rise_cnt;
        int p0;
        int m0;
        int n = 0;
        slv_reply[slv_idx] = 8'h99;
        send(8'hC3, 2'd2, 1'b1);
        while (rise_cnt - r0 < 3 && n < 200) begin
            tick(1);
            n++;
        end
        tick(1);
        p0 = rsp_cnt;
        #2;
        RESET_N = 1'b0;
        #1;
        total++;
        if ({spi_ss3, spi_ss2, spi_ss_io, spi_sck, busy} !== 5'b11100) begin
            bad++;
            $display("FAIL rst_async: ss3/ss2/io/sck/busy=%b, required 11100",
                     {spi_ss3, spi_ss2, spi_ss_io, spi_sck, busy});
        end
        tick(3);
        RESET_N = 1'b1;
        tick(3);
        total++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0 || rsp_cnt != p0) begin
            bad++;
            $display("FAIL rst_release: ready=%b busy=%b pulses=%0d, required 1 0 0",
                     cmd_ready, busy, rsp_cnt - p0);
        end
        m0 = mosi_hist.size();
        p0 = rsp_cnt;
        slv_reply[slv_idx] = 8'h5A;
        send(8'h96, 2'd2, 1'b1);
        wait_idle("rst");
        total++;
        if (mosi_byte(m0) !== 8'h96 || rsp_cnt - p0 != 1 || rsp_data !== 8'h5A) begin
            bad++;
            $display("FAIL rst_next: mosi=%h pulses=%0d data=%h, required 96 1 5a",
                     mosi_byte(m0), rsp_cnt - p0, rsp_data);
        end
    endtask

    task automatic test_sel_none();
        int r0 = rise_cnt;
        int m0 = mosi_hist.size();
        int l0 = io_low + ss2_low + ss3_low;
        send(8'h55, 2'd3, 1'b1);
        wait_idle("none");
        total++;
        if (io_low + ss2_low + ss3_low != l0 || rise_cnt - r0 != 8) begin
            bad++;
            $display("FAIL none_frame: select low cycles=%0d rises=%0d, required 0 and 8",
                     io_low + ss2_low + ss3_low - l0, rise_cnt - r0);
        end
        total++;
        if (rsp_data !== 8'hFF || mosi_byte(m0) !== 8'h55) begin
            bad++;
            $display("FAIL none_data: rsp=%h mosi=%h, required ff and 55", rsp_data, mosi_byte(m0));
        end
    endtask

    task automatic test_invariants();
        total++;
        if (multi_low != 0 || chg_hi != 0) begin
            bad++;
            $display("FAIL invariants: multi-select cycles=%0d select changes with sck high=%0d, required 0 0",
                     multi_low, chg_hi);
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) slv_reply[i] = 8'h00;
        test_reset();
        test_single();
        test_burst();
        test_latency_div4();
        test_wait_hold();
        test_reset_mid();
        test_sel_none();
        test_invariants();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
